ram_access_ctrl: RTL and testbench

Initiator-side controller that turns byte/half/word load-store requests from the core into word-wide accesses on a general RAM port. The RAM port has one write enable, one byte address, and an asynchronous read. The RAM has no byte enables, so the block performs read-modify-write for sub-word stores. It also sign- or zero-extends sub-word loads and flags misaligned or illegal requests. It sits between the load/store stage and each data RAM instance.

---
 rtl/ram_access_ctrl_pkg.sv | 29 ++
 rtl/ram_access_ctrl_if.sv | 35 +++
 rtl/ram_access_ctrl_lane_merge.sv | 51 +++++
 rtl/ram_access_ctrl.sv | 131 +++++++++++++
 tb/tb_ram_access_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared encodings for the RAM access controller: write/reset enables, access sizes,
// FSM states and the request legality rule.
package ram_access_ctrl_pkg;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic RST_ENABLE   = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_RMW_WR = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Size 3 is never legal; halves need even addresses, words need 4-byte alignment.
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            SIZE_W:  return (offset != 2'd0);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Load/store request, response and RAM port bundle of the RAM access controller.
interface ram_access_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]           req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [31:0]           rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, ram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, ram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  ram_we_o, ram_addr_o, ram_wdata_o
    );

endinterface

// File: rtl/ram_access_ctrl_lane_merge.sv
// Combinational lane logic: extracts and extends a loaded byte/half, and builds
// the full write word for stores by replacing the addressed lane(s).
module ram_lane_merge
    import ram_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic [31:0] wdata_merged
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic hit_b;
            logic hit_h;

            assign lanes[gi] = word[8*gi +: 8];
            assign hit_b     = (size == SIZE_B) && (offset == 2'(gi));
            assign hit_h     = (size == SIZE_H) && (offset[1] == 1'(gi / 2));

            // Word stores take every lane; a half store spreads wdata[15:0] over its two lanes.
            assign wdata_merged[8*gi +: 8] =
                (size == SIZE_W) ? wdata[8*gi +: 8] :
                hit_b            ? wdata[7:0] :
                hit_h            ? wdata[8*(gi % 2) +: 8] :
                                   word[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[offset];
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        rdata_ext = '0;
        case (size)
            SIZE_B:  rdata_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_H:  rdata_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SIZE_W:  rdata_ext = word;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Turns byte/half/word load-store requests into word accesses on a RAM without
// byte enables, using read-modify-write for sub-word stores.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
)(
    input  logic               clk,
    input  logic               rst,
    ram_access_ctrl_if.slave   bus
);

    state_t                state_reg;
    state_t                state_next;
    logic                  we_reg;
    logic [1:0]            size_reg;
    logic                  uns_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;
    logic [31:0]           merge_reg;
    logic [31:0]           rsp_rdata_reg;
    logic                  rsp_err_reg;

    logic                  handshake;
    logic                  illegal;
    logic                  ram_we;
    logic [31:0]           lane_word;
    logic [31:0]           rdata_ext;
    logic [31:0]           wdata_merged;

    assign bus.req_ready_o = (state_reg == ST_IDLE) && (rst != RST_ENABLE);
    assign handshake       = bus.req_valid_i && bus.req_ready_o;
    assign illegal         = req_illegal(bus.req_size_i, bus.req_addr_i[1:0]);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ram_we     = 1'b0;
        lane_word  = bus.ram_rdata_i;
        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = illegal ? ST_RESP : ST_ACC;
                end
            end
            ST_ACC: begin
                if (we_reg == WRITE_ENABLE && size_reg != SIZE_W) begin
                    state_next = ST_RMW_WR;
                end else begin
                    state_next = ST_RESP;
                end
                ram_we = (we_reg == WRITE_ENABLE) && (size_reg == SIZE_W);
            end
            ST_RMW_WR: begin
                state_next = ST_RESP;
                ram_we     = 1'b1;
                lane_word  = merge_reg;
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Any write attempted while reset is asserted is dropped.
        if (rst == RST_ENABLE) begin
            ram_we = 1'b0;
        end
    end

    ram_lane_merge u_lane_merge (
        .word         (lane_word),
        .offset       (addr_reg[1:0]),
        .size         (size_reg),
        .is_unsigned  (uns_reg),
        .wdata        (wdata_reg),
        .rdata_ext    (rdata_ext),
        .wdata_merged (wdata_merged)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            we_reg        <= 1'b0;
            size_reg      <= SIZE_B;
            uns_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            merge_reg     <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (handshake) begin
                        we_reg        <= bus.req_we_i;
                        size_reg      <= bus.req_size_i;
                        uns_reg       <= bus.req_unsigned_i;
                        addr_reg      <= bus.req_addr_i;
                        wdata_reg     <= bus.req_wdata_i;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= illegal;
                    end
                end
                ST_ACC: begin
                    if (we_reg != WRITE_ENABLE) begin
                        rsp_rdata_reg <= rdata_ext;
                    end else if (size_reg != SIZE_W) begin
                        merge_reg <= bus.ram_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid_o = (state_reg == ST_RESP);
    assign bus.rsp_rdata_o = rsp_rdata_reg;
    assign bus.rsp_err_o   = rsp_err_reg;
    assign bus.ram_we_o    = ram_we;
    assign bus.ram_addr_o  = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
    assign bus.ram_wdata_o = ram_we ? wdata_merged : 32'd0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed and randomized bench for ram_access_ctrl against a word-array reference model.
module tb_ram_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.ADDR_WIDTH(16)) bus ();

    ram_access_ctrl #(.ADDR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment RAM: asynchronous read, write on the clock edge.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (bus.ram_we_o) mem[bus.ram_addr_o[7:2]] <= bus.ram_wdata_o;
    end
    assign bus.ram_rdata_i = mem[bus.ram_addr_o[7:2]];

    logic [31:0] ref_mem [64];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what a byte-addressed memory with load extension would do.
    task automatic ref_model(input logic we, input logic [1:0] size, input logic uns,
                             input logic [15:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int wes);
        int idx;
        int off;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        idx   = int'(addr[7:2]);
        off   = int'(addr[1:0]);
        err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        rdata = 32'd0;
        wes   = 0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            w   = ref_mem[idx];
            if (size == 2'd0) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFFFF00;
            end else if (size == 2'd1) begin
                v = (w >> (8 * off)) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            rdata = v;
        end else begin
            wes = 1;
            if (size == 2'd2) begin
                lat          = 2;
                ref_mem[idx] = wdata;
            end else begin
                lat          = 3;
                mask         = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
                ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << (8 * off)) & mask);
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [15:0] addr,
                                 input logic [31:0] wdata, input int stall,
                                 output logic [31:0] got);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
        logic [31:0] got_rdata;
        logic        got_err;
        int          lat;
        int          wes;
        int          guard;
        ref_model(we, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat, exp_wes);
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        bus.rsp_ready_i    = (stall == 0);
        guard = 0;
        while (!bus.req_ready_o && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "/req_ready"}, 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        lat = 1;
        wes = 0;
        while (!bus.rsp_valid_o && lat < 10) begin
            if (bus.ram_we_o) begin
                wes++;
                check({tag, "/ram_addr"}, 32'(bus.ram_addr_o), 32'({addr[15:2], 2'b00}));
            end
            @(negedge clk);
            lat++;
        end
        got_rdata = bus.rsp_rdata_o;
        got_err   = bus.rsp_err_o;
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/we_cycles"}, 32'(wes), 32'(exp_wes));
        check({tag, "/rdata"}, got_rdata, exp_rdata);
        check({tag, "/err"}, 32'(got_err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(bus.rsp_valid_o), 32'd1);
            check({tag, "/hold_rdata"}, bus.rsp_rdata_o, got_rdata);
            check({tag, "/hold_err"}, 32'(bus.rsp_err_o), 32'(got_err));
            check({tag, "/hold_ready"}, 32'(bus.req_ready_o), 32'd0);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        check({tag, "/released_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "/released_ready"}, 32'(bus.req_ready_o), 32'd1);
        check({tag, "/ram_word"}, mem[addr[7:2]], ref_mem[addr[7:2]]);
        got = got_rdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "/rsp_rdata"}, bus.rsp_rdata_o, 32'd0);
        check({tag, "/rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
        check({tag, "/ram_we"}, 32'(bus.ram_we_o), 32'd0);
        check({tag, "/ram_addr"}, 32'(bus.ram_addr_o), 32'd0);
        check({tag, "/ram_wdata"}, bus.ram_wdata_o, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [1:0]  rsize;
        rst                = 1'b1;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 16'd0;
        bus.req_wdata_i    = 32'd0;
        bus.rsp_ready_i    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset/req_ready", 32'(bus.req_ready_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset/req_ready_after", 32'(bus.req_ready_o), 32'd1);

        for (int i = 0; i < 64; i++) begin
            run_and_check("init", 1'b1, 2'd2, 1'b0, 16'(i * 4), $urandom, 0, got);
        end

        run_and_check("sw_dead", 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 0, got);
        run_and_check("lw_dead", 1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 0, got);
        check("lw_dead/const", got, 32'hDEADBEEF);

        run_and_check("sw_pre", 1'b1, 2'd2, 1'b0, 16'h0020, 32'h11223344, 0, got);
        run_and_check("sb_aa", 1'b1, 2'd0, 1'b0, 16'h0022, 32'h000000AA, 0, got);
        check("sb_aa/const", mem[8], 32'h11AA3344);
        run_and_check("sh_beef", 1'b1, 2'd1, 1'b0, 16'h0022, 32'h0000BEEF, 0, got);
        check("sh_beef/const", mem[8], 32'hBEEF3344);

        run_and_check("sw_ext", 1'b1, 2'd2, 1'b0, 16'h0030, 32'h80FF7F01, 0, got);
        run_and_check("lb_s", 1'b0, 2'd0, 1'b0, 16'h0032, 32'd0, 0, got);
        check("lb_s/const", got, 32'hFFFFFFFF);
        run_and_check("lbu", 1'b0, 2'd0, 1'b1, 16'h0033, 32'd0, 0, got);
        check("lbu/const", got, 32'h00000080);
        run_and_check("lh_s", 1'b0, 2'd1, 1'b0, 16'h0030, 32'd0, 0, got);
        check("lh_s/const", got, 32'h00007F01);

        run_and_check("err_word", 1'b1, 2'd2, 1'b0, 16'h0031, 32'h12345678, 0, got);
        run_and_check("err_half", 1'b1, 2'd1, 1'b0, 16'h0033, 32'h0000FFFF, 0, got);
        run_and_check("err_size3", 1'b0, 2'd3, 1'b0, 16'h0030, 32'd0, 0, got);
        run_and_check("err_size3_st", 1'b1, 2'd3, 1'b0, 16'h0034, 32'hFFFFFFFF, 2, got);

        run_and_check("backpressure", 1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 5, got);

        // Abort a byte store by asserting reset during its write-back cycle.
        run_and_check("abort_pre", 1'b1, 2'd2, 1'b0, 16'h0020, 32'h11223344, 0, got);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_size_i  = 2'd0;
        bus.req_addr_i  = 16'h0021;
        bus.req_wdata_i = 32'h000000AA;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("abort/we_in_rmw", 32'(bus.ram_we_o), 32'd1);
        rst = 1'b1;
        #1;
        check("abort/we_gated", 32'(bus.ram_we_o), 32'd0);
        @(negedge clk);
        check_reset_outputs("abort");
        check("abort/ram_word", mem[8], 32'h11223344);
        rst = 1'b0;
        @(negedge clk);
        check("abort/no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        check("abort/ready", 32'(bus.req_ready_o), 32'd1);
        run_and_check("after_abort", 1'b0, 2'd0, 1'b1, 16'h0021, 32'd0, 0, got);
        check("after_abort/const", got, 32'h00000033);

        for (int i = 0; i < 80; i++) begin
            rsize = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
            run_and_check("rand", 1'($urandom_range(0, 1)), rsize, 1'($urandom_range(0, 1)),
                          16'($urandom_range(0, 255)), $urandom, $urandom_range(0, 2), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
